// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared definitions for the fetch/data RAM port arbiter
package mem_port_arbiter_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    typedef enum logic {
        GNT_FETCH = 1'b0,
        GNT_DATA  = 1'b1
    } gnt_t;

endpackage

// File: rtl/mem_port_arbiter_rr_grant2.sv
// rtl/mem_port_arbiter_rr_grant2.sv - two-way round-robin grant, one-hot, combinational
module rr_grant2
    import mem_port_arbiter_pkg::*;
(
    input  logic valid_f,
    input  logic valid_d,
    input  gnt_t last_grant,
    input  logic enable,
    output logic gnt_f,
    output logic gnt_d
);

    // A lone requester wins; on a tie the port not served last wins.
    always_comb begin
        gnt_f = 1'b0;
        gnt_d = 1'b0;
        if (enable) begin
            if (valid_f && valid_d) begin
                gnt_d = (last_grant == GNT_FETCH);
                gnt_f = (last_grant == GNT_DATA);
            end else begin
                gnt_f = valid_f;
                gnt_d = valid_d;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port RAM between fetch and load/store ports
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int MEM_LATENCY = 1
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                if_req_valid,
    output logic                if_req_ready,
    input  logic [ADDR_W-1:0]   if_req_addr,
    output logic                if_rsp_valid,
    output logic [WORD_W-1:0]   if_rsp_rdata,
    output logic                if_rsp_err,
    input  logic                d_req_valid,
    output logic                d_req_ready,
    input  logic [ADDR_W-1:0]   d_req_addr,
    input  logic [3:0]          d_req_we,
    input  logic [WORD_W-1:0]   d_req_wdata,
    output logic                d_rsp_valid,
    output logic [WORD_W-1:0]   d_rsp_rdata,
    output logic                d_rsp_err,
    output logic                mem_en,
    output logic [3:0]          mem_we,
    output logic [ADDR_W-3:0]   mem_addr,
    output logic [WORD_W-1:0]   mem_wdata,
    input  logic [WORD_W-1:0]   mem_rdata
);

    localparam int CNT_W = 3;
    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(DEPTH_WORDS * 4);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    gnt_t               last_q;
    gnt_t               gnt_id_q;
    logic [ADDR_W-3:0]  addr_q;
    logic [3:0]         we_q;
    logic [WORD_W-1:0]  wdata_q;
    logic               err_q;
    logic [WORD_W-1:0]  if_rdata_q, d_rdata_q;

    logic               gnt_f, gnt_d, hs, wait_last, sel_err;
    logic [ADDR_W-1:0]  sel_addr;
    logic [WORD_W-1:0]  rd_word;

    rr_grant2 u_rr (
        .valid_f    (if_req_valid),
        .valid_d    (d_req_valid),
        .last_grant (last_q),
        .enable     (state_q == ST_IDLE),
        .gnt_f      (gnt_f),
        .gnt_d      (gnt_d)
    );

    assign if_req_ready = gnt_f;
    assign d_req_ready  = gnt_d;
    assign hs           = gnt_f | gnt_d;
    assign sel_addr     = gnt_d ? d_req_addr : if_req_addr;
    assign sel_err      = (sel_addr[1:0] != 2'b00) || ({1'b0, sel_addr} >= ADDR_LIMIT);
    assign wait_last    = (state_q == ST_WAIT) && (cnt_q == CNT_W'(1));
    assign rd_word      = (we_q == 4'b0000) ? mem_rdata : '0;

    assign mem_en       = (state_q == ST_ISSUE);
    assign mem_we       = mem_en ? we_q : 4'b0000;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;

    assign if_rsp_valid = (state_q == ST_RESP) && (gnt_id_q == GNT_FETCH);
    assign d_rsp_valid  = (state_q == ST_RESP) && (gnt_id_q == GNT_DATA);
    assign if_rsp_err   = if_rsp_valid && err_q;
    assign d_rsp_err    = d_rsp_valid && err_q;
    assign if_rsp_rdata = if_rdata_q;
    assign d_rsp_rdata  = d_rdata_q;

    // Access sequencing: bad addresses skip straight to the response cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (hs) state_d = sel_err ? ST_RESP : ST_ISSUE;
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                cnt_d   = CNT_W'(MEM_LATENCY);
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and latency counter registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture the winning request at the handshake and remember who won.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_q   <= GNT_FETCH;
            gnt_id_q <= GNT_FETCH;
            addr_q   <= '0;
            we_q     <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
        end else if (hs) begin
            last_q   <= gnt_d ? GNT_DATA : GNT_FETCH;
            gnt_id_q <= gnt_d ? GNT_DATA : GNT_FETCH;
            addr_q   <= sel_addr[ADDR_W-1:2];
            we_q     <= gnt_d ? d_req_we : 4'b0000;
            wdata_q  <= gnt_d ? d_req_wdata : '0;
            err_q    <= sel_err;
        end
    end

    // Per-port response data, held until that port's next response.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else if (hs && sel_err) begin
            if (gnt_d) d_rdata_q  <= '0;
            else       if_rdata_q <= '0;
        end else if (wait_last) begin
            if (gnt_id_q == GNT_DATA) d_rdata_q  <= rd_word;
            else                      if_rdata_q <= rd_word;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int LAT = 1;

    logic        clock = 1'b0;
    logic        reset_n;
    always #5 clock = ~clock;

    logic        if_req_valid, if_req_ready, if_rsp_valid, if_rsp_err;
    logic [31:0] if_req_addr, if_rsp_rdata;
    logic        d_req_valid, d_req_ready, d_rsp_valid, d_rsp_err;
    logic [31:0] d_req_addr, d_req_wdata, d_rsp_rdata;
    logic [3:0]  d_req_we;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    logic        t3_if_req_valid, t3_if_req_ready, t3_if_rsp_valid, t3_if_rsp_err;
    logic [31:0] t3_if_req_addr, t3_if_rsp_rdata;
    logic        t3_d_req_valid, t3_d_req_ready, t3_d_rsp_valid, t3_d_rsp_err;
    logic [31:0] t3_d_req_addr, t3_d_req_wdata, t3_d_rsp_rdata;
    logic [3:0]  t3_d_req_we;
    logic        t3_mem_en;
    logic [3:0]  t3_mem_we;
    logic [29:0] t3_mem_addr;
    logic [31:0] t3_mem_wdata, t3_mem_rdata;

    mem_port_arbiter #(.ADDR_W(32), .DEPTH_WORDS(256), .MEM_LATENCY(LAT)) dut (
        .clock(clock), .reset_n(reset_n),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_rdata(if_rsp_rdata), .if_rsp_err(if_rsp_err),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
        .d_req_we(d_req_we), .d_req_wdata(d_req_wdata),
        .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata), .d_rsp_err(d_rsp_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(32), .DEPTH_WORDS(256), .MEM_LATENCY(3)) dut3 (
        .clock(clock), .reset_n(reset_n),
        .if_req_valid(t3_if_req_valid), .if_req_ready(t3_if_req_ready), .if_req_addr(t3_if_req_addr),
        .if_rsp_valid(t3_if_rsp_valid), .if_rsp_rdata(t3_if_rsp_rdata), .if_rsp_err(t3_if_rsp_err),
        .d_req_valid(t3_d_req_valid), .d_req_ready(t3_d_req_ready), .d_req_addr(t3_d_req_addr),
        .d_req_we(t3_d_req_we), .d_req_wdata(t3_d_req_wdata),
        .d_rsp_valid(t3_d_rsp_valid), .d_rsp_rdata(t3_d_rsp_rdata), .d_rsp_err(t3_d_rsp_err),
        .mem_en(t3_mem_en), .mem_we(t3_mem_we), .mem_addr(t3_mem_addr),
        .mem_wdata(t3_mem_wdata), .mem_rdata(t3_mem_rdata)
    );

    function automatic logic [31:0] init_word(input int i);
        if (i == 4) return 32'h0050_0093;
        if (i == 8) return 32'h1111_1111;
        return (32'(i) * 32'h9E37_79B9) ^ 32'hA5A5_0F0F;
    endfunction

    // RAM behind dut: read data valid only in the cycle after the strobe.
    logic [31:0] ram [256];
    logic [31:0] rd1;
    logic        rd1_v = 1'b0;
    logic        ram_ready = 1'b0;
    always @(posedge clock) begin
        if (!ram_ready) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
            ram_ready <= 1'b1;
        end else if (mem_en) begin
            rd1 <= ram[mem_addr[7:0]];
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) ram[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        rd1_v <= mem_en;
    end
    assign mem_rdata = rd1_v ? rd1 : 32'hBAD0_BAD0;

    // Read-only RAM view behind dut3 with three cycles of latency.
    logic [31:0] p3_d0, p3_d1, p3_d2;
    logic [2:0]  p3_v = 3'b000;
    always @(posedge clock) begin
        p3_d0 <= ram[t3_mem_addr[7:0]];
        p3_d1 <= p3_d0;
        p3_d2 <= p3_d1;
        p3_v  <= {p3_v[1:0], t3_mem_en};
    end
    assign t3_mem_rdata = p3_v[2] ? p3_d2 : 32'hBAD0_BAD0;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] ref_mem [256];
    bit          last_d;
    bit          f_pend, d_pend;
    logic [31:0] f_addr, d_addr, d_wdata;
    logic [3:0]  d_we;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Perform one arbitrated access on dut and check it cycle by cycle.
    task automatic serve();
        bit win_d, err;
        logic [31:0] a, wd, exp_rd;
        logic [3:0] we;
        int lat;
        if_req_valid = f_pend; if_req_addr = f_addr;
        d_req_valid = d_pend; d_req_addr = d_addr; d_req_we = d_we; d_req_wdata = d_wdata;
        #1;
        if (!f_pend && !d_pend) return;
        win_d = (f_pend && d_pend) ? !last_d : d_pend;
        check("if_req_ready", if_req_ready, !win_d);
        check("d_req_ready", d_req_ready, win_d);
        a = win_d ? d_addr : f_addr;
        we = win_d ? d_we : 4'b0000;
        wd = d_wdata;
        err = (a[1:0] != 2'b00) || (a >= 32'd1024);
        exp_rd = 32'h0;
        if (!err) begin
            if (we == 4'b0000) exp_rd = ref_mem[a[9:2]];
            else for (int b = 0; b < 4; b++) if (we[b]) ref_mem[a[9:2]][8*b +: 8] = wd[8*b +: 8];
        end
        lat = err ? 1 : LAT + 2;
        last_d = win_d;
        @(posedge clock); #1;
        if (win_d) begin d_pend = 0; d_req_valid = 0; d_req_addr = $urandom; end
        else begin f_pend = 0; if_req_valid = 0; if_req_addr = $urandom; end
        for (int k = 1; k <= lat; k++) begin
            @(negedge clock); #1;
            check("mem_en", mem_en, !err && k == 1);
            check("mem_we", mem_we, (!err && k == 1) ? we : 4'b0000);
            if (!err && k == 1) begin
                check("mem_addr", mem_addr, a[31:2]);
                if (win_d) check("mem_wdata", mem_wdata, wd);
            end
            check("busy_if_ready", if_req_ready, 1'b0);
            check("busy_d_ready", d_req_ready, 1'b0);
            check("if_rsp_valid", if_rsp_valid, !win_d && k == lat);
            check("d_rsp_valid", d_rsp_valid, win_d && k == lat);
            if (k == lat) begin
                check(win_d ? "d_rsp_rdata" : "if_rsp_rdata", win_d ? d_rsp_rdata : if_rsp_rdata, exp_rd);
                check(win_d ? "d_rsp_err" : "if_rsp_err", win_d ? d_rsp_err : if_rsp_err, err);
            end
        end
        @(negedge clock); #1;
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return {22'h0, 8'($urandom), 2'($urandom_range(1, 3))};
        if (r == 1) return {$urandom} | 32'h0000_0400 & 32'hFFFF_FFFC;
        return {22'h0, 8'($urandom), 2'b00};
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        reset_n = 0; last_d = 0; f_pend = 0; d_pend = 0;
        f_addr = 0; d_addr = 0; d_we = 0; d_wdata = 0;
        if_req_valid = 0; if_req_addr = 0; d_req_valid = 0; d_req_addr = 0; d_req_we = 0; d_req_wdata = 0;
        t3_if_req_valid = 0; t3_if_req_addr = 0; t3_d_req_valid = 0; t3_d_req_addr = 0;
        t3_d_req_we = 0; t3_d_req_wdata = 0;
        repeat (3) @(negedge clock);
        #1;
        check("rst_mem_en", mem_en, 1'b0);
        check("rst_mem_we", mem_we, 4'b0000);
        check("rst_if_rsp_valid", if_rsp_valid, 1'b0);
        check("rst_d_rsp_valid", d_rsp_valid, 1'b0);
        check("rst_if_rdata", if_rsp_rdata, 32'h0);
        check("rst_d_rdata", d_rsp_rdata, 32'h0);
        check("rst_mem_addr", mem_addr, 30'h0);
        if_req_valid = 1; #1;
        check("rst_ready_follows", if_req_ready, 1'b1);
        if_req_valid = 0; #1;
        check("rst_ready_drops", if_req_ready, 1'b0);
        @(negedge clock); reset_n = 1; #1;

        // tie after reset, then alternation with both held valid
        f_pend = 1; f_addr = 32'h14; d_pend = 1; d_addr = 32'h18; d_we = 0;
        serve(); check("tie1_winner_data", last_d, 1'b1);
        d_pend = 1; serve(); check("tie2_winner_fetch", last_d, 1'b0);
        f_pend = 1; serve(); check("tie3_winner_data", last_d, 1'b1);
        d_pend = 0; serve(); check("tie4_winner_fetch", last_d, 1'b0);

        // single fetch
        f_pend = 1; f_addr = 32'h10; serve();
        check("fetch_word4", if_rsp_rdata, 32'h0050_0093);

        // write then read back
        d_pend = 1; d_addr = 32'h20; d_we = 4'b0011; d_wdata = 32'hDEAD_BEEF; serve();
        check("write_rdata_zero", d_rsp_rdata, 32'h0);
        d_pend = 1; d_we = 0; serve();
        check("readback_merge", d_rsp_rdata, 32'h1111_BEEF);

        // error and boundary addresses
        d_pend = 1; d_addr = 32'h22; serve();
        f_pend = 1; f_addr = 32'h400; serve();
        f_pend = 1; f_addr = 32'h3FC; serve();
        d_pend = 1; d_addr = 32'hFFFF_FFFC; serve();

        // randomized traffic
        for (int it = 0; it < 60; it++) begin
            if (!f_pend && $urandom_range(0, 2) != 0) begin f_pend = 1; f_addr = rand_addr(); end
            if (!d_pend && $urandom_range(0, 2) != 0) begin
                d_pend = 1; d_addr = rand_addr();
                d_we = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0000;
                d_wdata = $urandom;
            end
            if (!f_pend && !d_pend) begin f_pend = 1; f_addr = rand_addr(); end
            serve();
        end
        while (f_pend || d_pend) serve();

        // reset during the wait phase of a fetch
        if_req_valid = 1; if_req_addr = 32'h10; #1;
        check("mid_ready", if_req_ready, 1'b1);
        @(posedge clock); #1; if_req_valid = 0;
        @(negedge clock); #1;
        check("mid_issue", mem_en, 1'b1);
        @(negedge clock); #1;
        reset_n = 0; #1;
        check("mid_rst_mem_en", mem_en, 1'b0);
        check("mid_rst_if_valid", if_rsp_valid, 1'b0);
        check("mid_rst_d_valid", d_rsp_valid, 1'b0);
        check("mid_rst_if_rdata", if_rsp_rdata, 32'h0);
        check("mid_rst_d_rdata", d_rsp_rdata, 32'h0);
        @(negedge clock); reset_n = 1; last_d = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock); #1;
            check("post_rst_no_if_rsp", if_rsp_valid, 1'b0);
            check("post_rst_no_mem_en", mem_en, 1'b0);
        end
        f_pend = 1; f_addr = 32'h10; d_pend = 1; d_addr = 32'h30; d_we = 0;
        serve(); check("post_rst_tie_data", last_d, 1'b1);
        serve();

        // three-cycle latency instance
        for (int j = 0; j < 3; j++) begin
            logic [31:0] a3;
            a3 = (j == 0) ? 32'h10 : {22'h0, 8'($urandom), 2'b00};
            t3_if_req_valid = 1; t3_if_req_addr = a3; #1;
            check("l3_ready", t3_if_req_ready, 1'b1);
            @(posedge clock); #1; t3_if_req_valid = 0;
            for (int k = 1; k <= 5; k++) begin
                @(negedge clock); #1;
                check("l3_mem_en", t3_mem_en, k == 1);
                check("l3_rsp_valid", t3_if_rsp_valid, k == 5);
                if (k == 5) check("l3_rdata", t3_if_rsp_rdata, ref_mem[a3[9:2]]);
            end
            @(negedge clock); #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
